spread_pipeline_mc: RTL

//   Multi-channel, pipelined Avellaneda-Stoikov spread engine; successor to the single-channel spread block.

---
 rtl/spread_pipeline_mc.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/spread_pipeline_mc.sv
// Multi-channel, 4-stage Avellaneda-Stoikov spread engine: spread = gamma*sigma^2*(T-t) + log_term,
// with a per-channel gamma table, valid/ready flow control, time clamping and saturation.
module spread_pipeline_mc #(
   parameter int                      FP_WORD_SIZE = 64,
   parameter int                      FRAC_BITS    = 32,
   parameter int                      DATA_WIDTH   = 32,
   parameter int                      NUM_CH       = 4,
   parameter int                      CH_W         = $clog2(NUM_CH),
   parameter logic [FP_WORD_SIZE-1:0] DEFAULT_RISK = 64'h0000_0000_1999_999A
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_data_valid,
   output logic                    o_ready,
   input  logic [CH_W-1:0]         i_ch,
   input  logic [DATA_WIDTH-1:0]   i_curr_time,
   input  logic [DATA_WIDTH-1:0]   i_terminal_time,
   input  logic [FP_WORD_SIZE-1:0] i_volatility,
   input  logic [FP_WORD_SIZE-1:0] i_logarithm,
   input  logic                    i_cfg_we,
   input  logic [CH_W-1:0]         i_cfg_ch,
   input  logic [FP_WORD_SIZE-1:0] i_cfg_risk,
   output logic                    o_data_valid,
   input  logic                    i_ready,
   output logic [CH_W-1:0]         o_ch,
   output logic [FP_WORD_SIZE-1:0] o_spread,
   output logic                    o_sat
);
   localparam int W  = FP_WORD_SIZE;
   localparam int PW = 2 * FP_WORD_SIZE;

   typedef struct packed {
      logic                  valid;
      logic                  sat;
      logic [CH_W-1:0]       ch;
      logic [DATA_WIDTH-1:0] dt;
      logic [W-1:0]          log_term;
      logic [W-1:0]          gamma;
      logic [W-1:0]          val;
   } front_t;

   typedef struct packed {
      logic                  valid;
      logic                  sat;
      logic [CH_W-1:0]       ch;
      logic [DATA_WIDTH-1:0] dt;
      logic [W-1:0]          log_term;
      logic [W-1:0]          g;
   } back_t;

   function automatic logic [PW-1:0] sext(input logic [W-1:0] x);
      return {{W{x[W-1]}}, x};
   endfunction

   // Returns {saturated, word}: a double-width value fits when its top W+1 bits are all equal.
   function automatic logic [W:0] sat_word(input logic [PW-1:0] x);
      logic [W:0] r;
      if (x[PW-1:W-1] == '0 || x[PW-1:W-1] == '1) r = {1'b0, x[W-1:0]};
      else if (x[PW-1])                           r = {2'b11, {(W-1){1'b0}}};
      else                                        r = {2'b10, {(W-1){1'b1}}};
      return r;
   endfunction

   front_t               s1_d, s1_q, s2_d, s2_q;
   back_t                s3_d, s3_q;
   logic                 o_valid_d, o_valid_q, o_sat_d, o_sat_q;
   logic [CH_W-1:0]      o_ch_d, o_ch_q;
   logic [W-1:0]         o_spread_d, o_spread_q;
   logic [W-1:0]         gamma_d [NUM_CH];
   logic [W-1:0]         gamma_q [NUM_CH];
   logic [W-1:0]         gamma_rd;
   logic                 stall;
   logic signed [PW-1:0] sq_full, g_full, r_full, s_full;
   logic [W:0]           v2_sat, g_sat, r_sat, s_sat;

   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      stall   = o_valid_q && !i_ready;
      o_ready = !stall;

      gamma_rd = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (i_ch == CH_W'(i)) gamma_rd = gamma_q[i];
      end

      gamma_d = gamma_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (i_cfg_we && i_cfg_ch == CH_W'(i)) gamma_d[i] = i_cfg_risk;
      end

      sq_full = $signed(sext(s1_q.val)) * $signed(sext(s1_q.val));
      v2_sat  = sat_word(sq_full >>> FRAC_BITS);
      g_full  = $signed(sext(s2_q.gamma)) * $signed(sext(s2_q.val));
      g_sat   = sat_word(g_full >>> FRAC_BITS);
      r_full  = $signed(sext(s3_q.g)) * $signed({{(PW-DATA_WIDTH){1'b0}}, s3_q.dt});
      r_sat   = sat_word(r_full);
      s_full  = $signed(sext(r_sat[W-1:0])) + $signed(sext(s3_q.log_term));
      s_sat   = sat_word(s_full);

      s1_d       = s1_q;
      s2_d       = s2_q;
      s3_d       = s3_q;
      o_valid_d  = o_valid_q;
      o_ch_d     = o_ch_q;
      o_spread_d = o_spread_q;
      o_sat_d    = o_sat_q;

      // A stall freezes every stage, bubbles included; data fields only load behind a valid beat.
      if (!stall) begin
         s1_d.valid = i_data_valid;
         if (i_data_valid) begin
            s1_d.ch       = i_ch;
            s1_d.gamma    = gamma_rd;
            s1_d.val      = i_volatility;
            s1_d.log_term = i_logarithm;
            s1_d.dt       = (i_curr_time >= i_terminal_time) ? '0 : i_terminal_time - i_curr_time;
            s1_d.sat      = i_curr_time > i_terminal_time;
         end

         s2_d.valid = s1_q.valid;
         if (s1_q.valid) begin
            s2_d     = s1_q;
            s2_d.val = v2_sat[W-1:0];
            s2_d.sat = s1_q.sat | v2_sat[W];
         end

         s3_d.valid = s2_q.valid;
         if (s2_q.valid) begin
            s3_d.ch       = s2_q.ch;
            s3_d.dt       = s2_q.dt;
            s3_d.log_term = s2_q.log_term;
            s3_d.g        = g_sat[W-1:0];
            s3_d.sat      = s2_q.sat | g_sat[W];
         end

         o_valid_d = s3_q.valid;
         if (s3_q.valid) begin
            o_ch_d     = s3_q.ch;
            o_spread_d = s_sat[W-1] ? '0 : s_sat[W-1:0];
            o_sat_d    = s3_q.sat | r_sat[W] | s_sat[W] | s_sat[W-1];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         s1_q       <= '0;
         s2_q       <= '0;
         s3_q       <= '0;
         o_valid_q  <= 1'b0;
         o_ch_q     <= '0;
         o_spread_q <= '0;
         o_sat_q    <= 1'b0;
         // NOTE: the gamma table is a small flop array, not RAM, so it can be reset in one cycle.
         gamma_q    <= '{default: DEFAULT_RISK};
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         s3_q       <= s3_d;
         o_valid_q  <= o_valid_d;
         o_ch_q     <= o_ch_d;
         o_spread_q <= o_spread_d;
         o_sat_q    <= o_sat_d;
         gamma_q    <= gamma_d;
      end
   end

   assign o_data_valid = o_valid_q;
   assign o_ch         = o_ch_q;
   assign o_spread     = o_spread_q;
   assign o_sat        = o_sat_q;
endmodule
